// File: rtl/smem_batch_ctrl.sv
// smem_batch_ctrl: polls a host handshake line, loads a read batch, streams core results back and posts fence/flag completion writes.
module smem_batch_ctrl #(
  parameter int          READ_NUM_WIDTH   = 6,
  parameter int          CL_PER_READ_LOG2 = 2,
  parameter int          MAX_OUTSTANDING  = 8,
  parameter logic [31:0] FLAG_VALUE       = 32'd16
) (
  input  logic                    CLK_200M,
  input  logic                    reset_n,
  input  logic                    core_start,
  input  logic                    stall,
  input  logic [57:0]             hand_ptr,
  input  logic [57:0]             input_base,
  input  logic [57:0]             output_base,
  output logic                    req_valid,
  output logic [57:0]             req_addr,
  input  logic                    rsp_valid,
  input  logic [511:0]            rsp_data,
  output logic                    batch_reset_n,
  output logic [READ_NUM_WIDTH:0] batch_size,
  output logic                    load_valid,
  output logic [511:0]            load_data,
  input  logic                    read_load_done,
  input  logic                    output_request,
  output logic                    output_permit,
  input  logic                    core_out_valid,
  input  logic [511:0]            core_out_data,
  input  logic                    core_out_finish,
  output logic                    wr_valid,
  output logic                    wr_fence,
  output logic [57:0]             wr_addr,
  output logic [511:0]            wr_data,
  output logic [15:0]             batch_cnt
);
  localparam int BW = READ_NUM_WIDTH + 1;
  localparam int TW = BW + CL_PER_READ_LOG2;
  typedef enum logic [3:0] {IDLE, POLL_REQ, POLL_WAIT, LOAD, RUN, OUTPUT, FENCE1, FLAG, FENCE2} state_t;
  state_t state, next;
  logic polling_tag;
  logic [TW-1:0] load_ptr, total;
  logic [7:0] outstanding;
  logic [57:0] out_idx;
  logic flag_hit, issue, wr_go;
  assign total = TW'(batch_size) << CL_PER_READ_LOG2;
  assign flag_hit = rsp_valid & (polling_tag ? rsp_data[482] : rsp_data[480]);
  assign issue = state == LOAD && core_start && !stall && load_ptr < total && outstanding < 8'(MAX_OUTSTANDING);
  assign wr_go = core_start && !stall;
  assign batch_reset_n = state != IDLE;
  always_comb begin
    next = state;
    if (!core_start) next = IDLE;
    else
      case (state)
        IDLE:      next = POLL_REQ;
        POLL_REQ:  next = stall ? POLL_REQ : POLL_WAIT;
        POLL_WAIT: if (rsp_valid) next = !flag_hit ? POLL_REQ : (rsp_data[448 +: BW] == '0 ? FLAG : LOAD);
        LOAD:      next = read_load_done ? RUN : LOAD;
        RUN:       next = output_request ? OUTPUT : RUN;
        OUTPUT:    next = core_out_finish ? FENCE1 : OUTPUT;
        FENCE1:    next = stall ? FENCE1 : FLAG;
        FLAG:      next = stall ? FLAG : FENCE2;
        FENCE2:    next = stall ? FENCE2 : IDLE;
        default:   next = IDLE;
      endcase
  end
  always_ff @(posedge CLK_200M or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge CLK_200M or negedge reset_n) begin
    if (!reset_n) begin
      req_valid     <= 1'b0;
      req_addr      <= '0;
      batch_size    <= '0;
      load_valid    <= 1'b0;
      load_data     <= '0;
      output_permit <= 1'b0;
      wr_valid      <= 1'b0;
      wr_fence      <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      batch_cnt     <= '0;
      polling_tag   <= 1'b0;
      load_ptr      <= '0;
      outstanding   <= '0;
      out_idx       <= '0;
    end else begin
      req_valid  <= 1'b0;
      load_valid <= 1'b0;
      wr_valid   <= 1'b0;
      wr_fence   <= 1'b0;
      outstanding <= outstanding + 8'(issue) - 8'(rsp_valid && outstanding != 8'd0);
      if (state == POLL_REQ && wr_go) begin
        req_valid <= 1'b1;
        req_addr  <= hand_ptr;
      end
      if (issue) begin
        req_valid <= 1'b1;
        req_addr  <= input_base + 58'(load_ptr);
        load_ptr  <= load_ptr + TW'(1);
      end
      if (state == POLL_WAIT && core_start && flag_hit) begin
        batch_size  <= rsp_data[448 +: BW];
        polling_tag <= ~polling_tag;
      end
      if (state == LOAD && core_start && rsp_valid) begin
        load_valid <= 1'b1;
        load_data  <= rsp_data;
      end
      if (state == RUN && core_start && output_request) output_permit <= 1'b1;
      if (state == OUTPUT && core_start && core_out_valid) begin
        wr_valid <= 1'b1;
        wr_addr  <= output_base + out_idx;
        wr_data  <= core_out_data;
        out_idx  <= out_idx + 58'd1;
      end
      if ((state == FENCE1 || state == FENCE2) && wr_go) begin
        wr_valid <= 1'b1;
        wr_fence <= 1'b1;
        wr_addr  <= '0;
        wr_data  <= {1'b1, 511'b0};
      end
      if (state == FLAG && wr_go) begin
        wr_valid <= 1'b1;
        wr_addr  <= hand_ptr;
        wr_data  <= {FLAG_VALUE, 480'b0};
      end
      if (state == FENCE2 && wr_go) batch_cnt <= batch_cnt + 16'd1;
      // Per-batch bookkeeping restarts whenever the batch ends or is aborted.
      if (next == IDLE) begin
        load_ptr      <= '0;
        outstanding   <= '0;
        out_idx       <= '0;
        output_permit <= 1'b0;
      end
    end
  end
endmodule
